// File: rtl/algo_mrnwp_1r1w_stash_top.sv
// -----------------------------------------------------------------------------
// algo_mrnwp_1r1w_stash_top
//
// Multi-read / multi-write port memory built from NUMVBNK 1r1w bank macros.
// Each bank has a small write stash. Same-cycle writes that collide on one bank
// are parked in the stash, coalesced with newer writes to the same row, and
// drained one per cycle. Reads that hit a stashed row are forwarded from the
// stash. After reset every bank is swept to zero before commands are accepted.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ready                     commands accepted this cycle
//   write/wr_badr/wr_radr/din per-port write command (NUMWRPT ports)
//   read/rd_badr/rd_radr      per-port read command (NUMRDPT ports)
//   rd_vld/rd_dout/rd_cfl     read response, SRAM_DELAY+1 cycles after issue
//   t1_writeA/addrA/dinA      bank write port, one per bank
//   t1_readB/addrB/doutB      bank read port, doutB valid SRAM_DELAY later
// -----------------------------------------------------------------------------
module algo_mrnwp_1r1w_stash_top #(
    parameter int WIDTH      = 32,
    parameter int NUMVBNK    = 8,
    parameter int BITVBNK    = 3,
    parameter int NUMVROW    = 1024,
    parameter int BITVROW    = 10,
    parameter int NUMRDPT    = 2,
    parameter int NUMWRPT    = 3,
    parameter int NUMSTSH    = 4,
    parameter int BITSTSH    = 3,
    parameter int SRAM_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUMWRPT-1:0]         write,
    input  logic [NUMWRPT*BITVBNK-1:0] wr_badr,
    input  logic [NUMWRPT*BITVROW-1:0] wr_radr,
    input  logic [NUMWRPT*WIDTH-1:0]   din,
    input  logic [NUMRDPT-1:0]         read,
    input  logic [NUMRDPT*BITVBNK-1:0] rd_badr,
    input  logic [NUMRDPT*BITVROW-1:0] rd_radr,
    output logic [NUMRDPT-1:0]         rd_vld,
    output logic [NUMRDPT*WIDTH-1:0]   rd_dout,
    output logic [NUMRDPT-1:0]         rd_cfl,
    output logic [NUMVBNK-1:0]         t1_writeA,
    output logic [NUMVBNK*BITVROW-1:0] t1_addrA,
    output logic [NUMVBNK*WIDTH-1:0]   t1_dinA,
    output logic [NUMVBNK-1:0]         t1_readB,
    output logic [NUMVBNK*BITVROW-1:0] t1_addrB,
    input  logic [NUMVBNK*WIDTH-1:0]   t1_doutB
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic               vld;
        logic               cfl;
        logic               hit;
        logic [BITVBNK-1:0] bank;
        logic [WIDTH-1:0]   dat;
    } rd_pipe_t;

    state_t             state, state_nxt;
    logic [BITVROW-1:0] init_cnt;
    logic               accept;

    // Stash: entry 0 is the oldest; entries [0, st_cnt) are valid.
    logic [BITVROW-1:0] st_row [NUMVBNK][NUMSTSH];
    logic [WIDTH-1:0]   st_dat [NUMVBNK][NUMSTSH];
    logic [BITSTSH-1:0] st_cnt [NUMVBNK];
    logic [BITVROW-1:0] nx_row [NUMVBNK][NUMSTSH];
    logic [WIDTH-1:0]   nx_dat [NUMVBNK][NUMSTSH];
    logic [BITSTSH-1:0] nx_cnt [NUMVBNK];
    logic               stash_ok;

    logic [BITVBNK-1:0] wbk [NUMWRPT];
    logic [BITVROW-1:0] wrw [NUMWRPT];
    logic [WIDTH-1:0]   wdt [NUMWRPT];
    logic [NUMWRPT-1:0] wr_ok, wr_hit;

    logic [BITVBNK-1:0] rbk [NUMRDPT];
    logic [BITVROW-1:0] rrw [NUMRDPT];
    rd_pipe_t           issue [NUMRDPT];
    rd_pipe_t           pipe  [SRAM_DELAY][NUMRDPT];

    // Commands are also blocked in the reset cycle so nothing lands in a
    // stash that is about to be cleared.
    assign accept = ready & ~rst;

    // ---------------- init sweep FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == BITVROW'(NUMVROW - 1)) state_nxt = ST_RUN;
    end

    // ---------------- write port decode, dedup, stash hit ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned and infers a latch.
        for (int p = 0; p < NUMWRPT; p++) begin
            wbk[p]    = wr_badr[p*BITVBNK +: BITVBNK];
            wrw[p]    = wr_radr[p*BITVROW +: BITVROW];
            wdt[p]    = din[p*WIDTH +: WIDTH];
            wr_ok[p]  = accept & write[p];
            wr_hit[p] = 1'b0;
        end
        for (int p = 0; p < NUMWRPT; p++) begin
            // A higher port to the same address wins; this one is dropped.
            for (int q = p + 1; q < NUMWRPT; q++)
                if (write[q] && wbk[q] == wbk[p] && wrw[q] == wrw[p]) wr_ok[p] = 1'b0;
            for (int e = 0; e < NUMSTSH; e++)
                if (wr_ok[p] && BITSTSH'(e) < st_cnt[wbk[p]] && st_row[wbk[p]][e] == wrw[p])
                    wr_hit[p] = 1'b1;
        end
    end

    // ---------------- per-bank write scheduling ----------------
    always_comb begin
        int   k;
        logic do_pop, bypassed;
        logic [WIDTH-1:0] co_dat [NUMSTSH];
        t1_writeA = '0;
        t1_addrA  = '0;
        t1_dinA   = '0;
        k         = 0;
        do_pop    = 1'b0;
        bypassed  = 1'b0;
        for (int b = 0; b < NUMVBNK; b++) begin
            nx_cnt[b] = st_cnt[b];
            for (int e = 0; e < NUMSTSH; e++) begin
                nx_row[b][e] = st_row[b][e];
                nx_dat[b][e] = st_dat[b][e];
            end
        end
        for (int e = 0; e < NUMSTSH; e++) co_dat[e] = '0;

        if (!rst && state == ST_INIT) begin
            for (int b = 0; b < NUMVBNK; b++) begin
                t1_writeA[b]                  = 1'b1;
                t1_addrA[b*BITVROW +: BITVROW] = init_cnt;
            end
        end else if (!rst) begin
            for (int b = 0; b < NUMVBNK; b++) begin
                // Coalesce incoming writes into matching stash entries.
                for (int e = 0; e < NUMSTSH; e++) begin
                    co_dat[e] = st_dat[b][e];
                    for (int p = 0; p < NUMWRPT; p++)
                        if (wr_ok[p] && wbk[p] == BITVBNK'(b) && BITSTSH'(e) < st_cnt[b] &&
                            st_row[b][e] == wrw[p])
                            co_dat[e] = wdt[p];
                end
                do_pop   = (st_cnt[b] != '0);
                bypassed = 1'b0;
                k        = int'(st_cnt[b]);
                if (do_pop) begin
                    t1_writeA[b]                   = 1'b1;
                    t1_addrA[b*BITVROW +: BITVROW] = st_row[b][0];
                    t1_dinA[b*WIDTH +: WIDTH]      = co_dat[0];
                    k = k - 1;
                end
                for (int e = 0; e < NUMSTSH; e++) begin
                    if (do_pop && e > 0 && BITSTSH'(e) < st_cnt[b]) begin
                        nx_row[b][e-1] = st_row[b][e];
                        nx_dat[b][e-1] = co_dat[e];
                    end else if (!do_pop) begin
                        nx_dat[b][e] = co_dat[e];
                    end
                end
                // Non-coalesced writes: bypass the first if the stash is empty,
                // append the rest in port order.
                for (int p = 0; p < NUMWRPT; p++) begin
                    if (wr_ok[p] && !wr_hit[p] && wbk[p] == BITVBNK'(b)) begin
                        if (!do_pop && !bypassed) begin
                            bypassed                       = 1'b1;
                            t1_writeA[b]                   = 1'b1;
                            t1_addrA[b*BITVROW +: BITVROW] = wrw[p];
                            t1_dinA[b*WIDTH +: WIDTH]      = wdt[p];
                        end else begin
                            for (int s = 0; s < NUMSTSH; s++)
                                if (s == k) begin
                                    nx_row[b][s] = wrw[p];
                                    nx_dat[b][s] = wdt[p];
                                end
                            k = k + 1;
                        end
                    end
                end
                nx_cnt[b] = BITSTSH'(k);
            end
        end
    end

    always_comb begin
        stash_ok = 1'b1;
        for (int b = 0; b < NUMVBNK; b++)
            if (nx_cnt[b] > BITSTSH'(NUMSTSH - NUMWRPT)) stash_ok = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            for (int b = 0; b < NUMVBNK; b++) st_cnt[b] <= '0;
        end else begin
            ready <= (state_nxt == ST_RUN) && stash_ok;
            for (int b = 0; b < NUMVBNK; b++) st_cnt[b] <= nx_cnt[b];
        end
    end

    // NOTE: stash storage has no reset; the counts alone define validity, so
    // clearing the data array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        st_row <= nx_row;
        st_dat <= nx_dat;
    end

    // ---------------- read issue ----------------
    always_comb begin
        t1_readB = '0;
        t1_addrB = '0;
        for (int p = 0; p < NUMRDPT; p++) begin
            rbk[p]       = rd_badr[p*BITVBNK +: BITVBNK];
            rrw[p]       = rd_radr[p*BITVROW +: BITVROW];
            issue[p]     = '0;
            issue[p].vld = accept & read[p];
            issue[p].bank = rbk[p];
        end
        for (int p = 0; p < NUMRDPT; p++) begin
            // Lowest port wins a bank; higher ports to the same bank are flagged.
            for (int q = 0; q < p; q++)
                if (accept && read[q] && rbk[q] == rbk[p] && issue[p].vld) begin
                    issue[p].vld = 1'b0;
                    issue[p].cfl = 1'b1;
                end
            for (int e = 0; e < NUMSTSH; e++)
                if (BITSTSH'(e) < st_cnt[rbk[p]] && st_row[rbk[p]][e] == rrw[p]) begin
                    issue[p].hit = 1'b1;
                    issue[p].dat = st_dat[rbk[p]][e];
                end
            if (issue[p].vld) begin
                t1_readB[rbk[p]]                   = 1'b1;
                t1_addrB[rbk[p]*BITVROW +: BITVROW] = rrw[p];
            end
        end
    end

    // ---------------- read pipeline ----------------
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUMRDPT; p++) begin
            if (rst) begin
                for (int s = 0; s < SRAM_DELAY; s++) begin
                    pipe[s][p].vld <= 1'b0;
                    pipe[s][p].cfl <= 1'b0;
                end
                rd_vld[p]                 <= 1'b0;
                rd_cfl[p]                 <= 1'b0;
                rd_dout[p*WIDTH +: WIDTH] <= '0;
            end else begin
                pipe[0][p] <= issue[p];
                for (int s = 1; s < SRAM_DELAY; s++) pipe[s][p] <= pipe[s-1][p];
                rd_vld[p] <= pipe[SRAM_DELAY-1][p].vld;
                rd_cfl[p] <= pipe[SRAM_DELAY-1][p].cfl;
                if (!pipe[SRAM_DELAY-1][p].vld)
                    rd_dout[p*WIDTH +: WIDTH] <= '0;
                else if (pipe[SRAM_DELAY-1][p].hit)
                    rd_dout[p*WIDTH +: WIDTH] <= pipe[SRAM_DELAY-1][p].dat;
                else
                    rd_dout[p*WIDTH +: WIDTH] <= t1_doutB[pipe[SRAM_DELAY-1][p].bank*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_algo_mrnwp_1r1w_stash_top.sv
// -----------------------------------------------------------------------------
// Testbench for algo_mrnwp_1r1w_stash_top: behavioural bank macros with a
// two-cycle read-before-write read port, plus directed scenario tasks.
// -----------------------------------------------------------------------------
module tb_algo_mrnwp_1r1w_stash_top;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [2:0]    write;
    logic [8:0]    wr_badr;
    logic [29:0]   wr_radr;
    logic [95:0]   din;
    logic [1:0]    read;
    logic [5:0]    rd_badr;
    logic [19:0]   rd_radr;
    logic [1:0]    rd_vld;
    logic [63:0]   rd_dout;
    logic [1:0]    rd_cfl;
    logic [7:0]    t1_writeA;
    logic [79:0]   t1_addrA;
    logic [255:0]  t1_dinA;
    logic [7:0]    t1_readB;
    logic [79:0]   t1_addrB;
    logic [255:0]  t1_doutB;

    int checks   = 0;
    int failures = 0;

    algo_mrnwp_1r1w_stash_top dut (
        .clk(clk), .rst(rst), .ready(ready),
        .write(write), .wr_badr(wr_badr), .wr_radr(wr_radr), .din(din),
        .read(read), .rd_badr(rd_badr), .rd_radr(rd_radr),
        .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_cfl(rd_cfl),
        .t1_writeA(t1_writeA), .t1_addrA(t1_addrA), .t1_dinA(t1_dinA),
        .t1_readB(t1_readB), .t1_addrB(t1_addrB), .t1_doutB(t1_doutB)
    );

    always #5 clk = ~clk;

    // Bank macro model: read-before-write, read data two cycles after readB.
    logic [31:0] mem [8][1024];
    logic [31:0] s1  [8];
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (t1_readB[b]) s1[b] <= mem[b][t1_addrB[b*10 +: 10]];
            t1_doutB[b*32 +: 32] <= s1[b];
            if (t1_writeA[b]) mem[b][t1_addrA[b*10 +: 10]] <= t1_dinA[b*32 +: 32];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = '0;
        read  = '0;
    endtask

    task automatic set_wr(input int p, input int bank, input int row, input logic [31:0] data);
        write[p]            = 1'b1;
        wr_badr[p*3 +: 3]   = 3'(bank);
        wr_radr[p*10 +: 10] = 10'(row);
        din[p*32 +: 32]     = data;
    endtask

    // Issues one read in the current cycle, clears all commands after the
    // issuing edge, and returns the response seen three cycles later.
    task automatic do_read(input int p, input int bank, input int row,
                           output logic vld, output logic cfl, output logic [31:0] dat);
        read[p]             = 1'b1;
        rd_badr[p*3 +: 3]   = 3'(bank);
        rd_radr[p*10 +: 10] = 10'(row);
        step();
        idle();
        step();
        step();
        vld = rd_vld[p];
        cfl = rd_cfl[p];
        dat = rd_dout[p*32 +: 32];
    endtask

    // Waits for ready; returns how many cycles it was low (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        idle();
        wr_badr = '0; wr_radr = '0; din = '0; rd_badr = '0; rd_radr = '0;
        step(); step(); step();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (rd_vld !== 2'b00) begin failures++; $display("FAIL reset_rd_vld: got %b expected 00", rd_vld); end
        checks++; if (rd_cfl !== 2'b00) begin failures++; $display("FAIL reset_rd_cfl: got %b expected 00", rd_cfl); end
        checks++; if (rd_dout !== 64'h0) begin failures++; $display("FAIL reset_rd_dout: got %h expected 0", rd_dout); end
        checks++; if (t1_writeA !== 8'h00) begin failures++; $display("FAIL reset_writeA: got %h expected 00", t1_writeA); end
        checks++; if (t1_readB !== 8'h00) begin failures++; $display("FAIL reset_readB: got %h expected 00", t1_readB); end
        rst = 1'b0;
        #1;
        checks++; if (t1_writeA !== 8'hFF || t1_addrA !== 80'h0) begin failures++;
            $display("FAIL init_first_write: got writeA=%h addrA=%h expected FF/0", t1_writeA, t1_addrA); end
        wait_ready(n);
        checks++; if (n !== 1024) begin failures++; $display("FAIL init_length: got %0d expected 1024", n); end
    endtask

    task automatic test_init_read();
        logic v, c; logic [31:0] d;
        do_read(0, 5, 1023, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++;
            $display("FAIL init_read_b5r1023: got vld=%b data=%h expected 1/0", v, d); end
    endtask

    task automatic test_three_way();
        logic v, c; logic [31:0] d;
        set_wr(0, 2, 10, 32'hAAAA_0001);
        set_wr(1, 2, 11, 32'hBBBB_0002);
        set_wr(2, 2, 12, 32'hCCCC_0003);
        #1;
        checks++; if (t1_writeA !== 8'h04 || t1_addrA[20 +: 10] !== 10'd10 || t1_dinA[64 +: 32] !== 32'hAAAA_0001) begin
            failures++; $display("FAIL three_way_bypass: got we=%h row=%0d data=%h expected 04/10/AAAA0001",
                                 t1_writeA, t1_addrA[20 +: 10], t1_dinA[64 +: 32]); end
        step();
        idle();
        #1;
        checks++; if (t1_writeA !== 8'h04 || t1_addrA[20 +: 10] !== 10'd11 || t1_dinA[64 +: 32] !== 32'hBBBB_0002) begin
            failures++; $display("FAIL three_way_drain1: got we=%h row=%0d data=%h expected 04/11/BBBB0002",
                                 t1_writeA, t1_addrA[20 +: 10], t1_dinA[64 +: 32]); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL three_way_ready_low: got %b expected 0", ready); end
        step();
        checks++; if (t1_writeA !== 8'h04 || t1_addrA[20 +: 10] !== 10'd12 || t1_dinA[64 +: 32] !== 32'hCCCC_0003) begin
            failures++; $display("FAIL three_way_drain2: got we=%h row=%0d data=%h expected 04/12/CCCC0003",
                                 t1_writeA, t1_addrA[20 +: 10], t1_dinA[64 +: 32]); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL three_way_ready_back: got %b expected 1", ready); end
        // Row 12 is still in the stash here, so this read is forwarded.
        do_read(0, 2, 12, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'hCCCC_0003) begin failures++; $display("FAIL three_way_rd12: got %b/%h expected 1/CCCC0003", v, d); end
        do_read(0, 2, 11, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'hBBBB_0002) begin failures++; $display("FAIL three_way_rd11: got %b/%h expected 1/BBBB0002", v, d); end
        do_read(1, 2, 10, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'hAAAA_0001) begin failures++; $display("FAIL three_way_rd10: got %b/%h expected 1/AAAA0001", v, d); end
    endtask

    task automatic test_coalesce();
        logic v, c; logic [31:0] d;
        set_wr(0, 6, 20, 32'h6000_0020);
        set_wr(1, 6, 21, 32'h6000_0021);
        set_wr(2, 6, 22, 32'h6000_0022);
        step(); idle(); step();
        // Stash holds only row 22; the new write to 22 merges into the drain.
        set_wr(0, 6, 22, 32'hD00D_0022);
        set_wr(1, 6, 23, 32'hE00E_0023);
        #1;
        checks++; if (t1_writeA !== 8'h40 || t1_addrA[60 +: 10] !== 10'd22 || t1_dinA[192 +: 32] !== 32'hD00D_0022) begin
            failures++; $display("FAIL coalesce_drain: got we=%h row=%0d data=%h expected 40/22/D00D0022",
                                 t1_writeA, t1_addrA[60 +: 10], t1_dinA[192 +: 32]); end
        step(); idle(); #1;
        checks++; if (t1_writeA !== 8'h40 || t1_addrA[60 +: 10] !== 10'd23 || t1_dinA[192 +: 32] !== 32'hE00E_0023) begin
            failures++; $display("FAIL coalesce_append: got we=%h row=%0d data=%h expected 40/23/E00E0023",
                                 t1_writeA, t1_addrA[60 +: 10], t1_dinA[192 +: 32]); end
        step();
        do_read(0, 6, 22, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'hD00D_0022) begin failures++; $display("FAIL coalesce_rd22: got %b/%h expected 1/D00D0022", v, d); end
        do_read(0, 6, 21, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'h6000_0021) begin failures++; $display("FAIL coalesce_rd21: got %b/%h expected 1/60000021", v, d); end
    endtask

    task automatic test_same_addr();
        logic v, c; logic [31:0] d;
        set_wr(0, 1, 7, 32'h11);
        set_wr(2, 1, 7, 32'h22);
        #1;
        checks++; if (t1_writeA !== 8'h02 || t1_dinA[32 +: 32] !== 32'h22) begin failures++;
            $display("FAIL same_addr_winner: got we=%h data=%h expected 02/22", t1_writeA, t1_dinA[32 +: 32]); end
        do_read(0, 1, 7, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL same_addr_old: got %b/%h expected 1/0", v, d); end
        do_read(0, 1, 7, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'h22) begin failures++; $display("FAIL same_addr_new: got %b/%h expected 1/22", v, d); end
    endtask

    task automatic test_back_to_back();
        logic v, c; logic [31:0] d;
        logic exp_rdy [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic acc [9];
        for (int cyc = 0; cyc < 9; cyc++) begin
            acc[cyc] = exp_rdy[cyc];
            for (int p = 0; p < 3; p++) set_wr(p, 3, 100 + cyc*3 + p, 32'hB000_0000 | 32'(100 + cyc*3 + p));
            #1;
            checks++; if (ready !== exp_rdy[cyc]) begin failures++;
                $display("FAIL bp_ready_c%0d: got %b expected %b", cyc, ready, exp_rdy[cyc]); end
            step();
        end
        idle();
        for (int i = 0; i < 5; i++) step();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL bp_recover: got %b expected 1", ready); end
        for (int cyc = 0; cyc < 9; cyc++)
            for (int p = 0; p < 3; p++) begin
                do_read(0, 3, 100 + cyc*3 + p, v, c, d);
                checks++;
                if (v !== 1'b1 || d !== (acc[cyc] ? (32'hB000_0000 | 32'(100 + cyc*3 + p)) : 32'h0)) begin
                    failures++; $display("FAIL bp_readback_r%0d: got %b/%h expected acc=%b", 100 + cyc*3 + p, v, d, acc[cyc]);
                end
            end
    endtask

    task automatic test_conflict();
        read = 2'b11;
        rd_badr = {3'd4, 3'd4};
        rd_radr = {10'd5, 10'd0};
        #1;
        checks++; if (t1_readB !== 8'h10 || t1_addrB[40 +: 10] !== 10'd0) begin failures++;
            $display("FAIL conflict_issue: got readB=%h row=%0d expected 10/0", t1_readB, t1_addrB[40 +: 10]); end
        step(); idle(); step(); step();
        checks++; if (rd_vld !== 2'b01) begin failures++; $display("FAIL conflict_vld: got %b expected 01", rd_vld); end
        checks++; if (rd_cfl !== 2'b10) begin failures++; $display("FAIL conflict_cfl: got %b expected 10", rd_cfl); end
        checks++; if (rd_dout[31:0] !== 32'h0) begin failures++; $display("FAIL conflict_data: got %h expected 0", rd_dout[31:0]); end
    endtask

    task automatic test_reset_mid();
        logic v, c; logic [31:0] d;
        int n;
        set_wr(0, 7, 30, 32'h7070_0030);
        set_wr(1, 7, 31, 32'h7070_0031);
        set_wr(2, 7, 32, 32'h7070_0032);
        read = 2'b01; rd_badr[2:0] = 3'd0; rd_radr[9:0] = 10'd0;
        step();
        idle();
        rst = 1'b1;
        #1;
        checks++; if (t1_writeA !== 8'h00) begin failures++; $display("FAIL rstmid_no_drain: got %h expected 00", t1_writeA); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
        checks++; if (t1_writeA !== 8'hFF || t1_addrA[70 +: 10] !== 10'd0) begin failures++;
            $display("FAIL rstmid_init_restart: got we=%h row=%0d expected FF/0", t1_writeA, t1_addrA[70 +: 10]); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rd_vld !== 2'b00) begin failures++; $display("FAIL rstmid_rd_vld_%0d: got %b expected 00", i, rd_vld); end
        end
        wait_ready(n);
        checks++; if (n !== 1021) begin failures++; $display("FAIL rstmid_init_length: got %0d expected 1021", n); end
        do_read(0, 7, 31, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL rstmid_rd31: got %b/%h expected 1/0", v, d); end
        do_read(1, 7, 32, v, c, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL rstmid_rd32: got %b/%h expected 1/0", v, d); end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_three_way();
        test_coalesce();
        test_same_addr();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
